// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_acc16 / alu_sequencer
// Purpose  : 16-bit accumulator ALU plus a program-driven controller.
//            The sequencer buffers (opcode, operand) instructions in a FIFO,
//            resets and seeds the ALU, issues one instruction every two
//            cycles and stops on completion or on the first ALU error.
// Ports    : clk, rst                    - clock, sync active-high reset
//            in_valid/in_ready/in_op/in_b - instruction write handshake
//            start, a_init                - program launch, seed operand
//            busy, done                   - run status, end-of-program pulse
//            err, err_index               - abort flag, faulting index
//            result                       - accumulator at program end
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// alu_acc16: accumulator ALU. The first operation after reset takes A from the
// a input; every later operation takes A from the accumulator. en=0 holds all
// state. status is set when the operation lost information (carry out of ADD,
// borrow from SUB, bits above 16 from MULT/SHIFTL).
// ----------------------------------------------------------------------------
module alu_acc16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [2:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] acc,
  output logic        status
);
  localparam logic [2:0] OP_ADD    = 3'd0;
  localparam logic [2:0] OP_SUB    = 3'd1;
  localparam logic [2:0] OP_MULT   = 3'd2;
  localparam logic [2:0] OP_SHIFTL = 3'd3;
  localparam logic [2:0] OP_AND    = 3'd4;
  localparam logic [2:0] OP_OR     = 3'd5;
  localparam logic [2:0] OP_XOR    = 3'd6;
  localparam logic [2:0] OP_NOT    = 3'd7;

  logic        first;
  logic [15:0] opa;
  logic [31:0] wide;
  logic        ovf;

  assign opa = first ? a : acc;

  always_comb begin
    wide = 32'd0;
    ovf  = 1'b0;
    case (op)
      OP_ADD: begin
        wide = 32'(opa) + 32'(b);
        ovf  = |wide[31:16];
      end
      OP_SUB: begin
        wide = 32'(opa) - 32'(b);
        ovf  = (b > opa);
      end
      OP_MULT: begin
        wide = 32'(opa) * 32'(b);
        ovf  = |wide[31:16];
      end
      OP_SHIFTL: begin
        wide = 32'(opa) << b[3:0];
        ovf  = |wide[31:16];
      end
      OP_AND:  wide = {16'h0000, opa & b};
      OP_OR:   wide = {16'h0000, opa | b};
      OP_XOR:  wide = {16'h0000, opa ^ b};
      OP_NOT:  wide = {16'h0000, ~opa};
      default: wide = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= 16'h0000;
      first  <= 1'b1;
      status <= 1'b0;
    end else if (en) begin
      acc    <= wide[15:0];
      status <= ovf;
      first  <= 1'b0;
    end
  end
endmodule

// ----------------------------------------------------------------------------
// alu_sequencer: top level controller.
// ----------------------------------------------------------------------------
module alu_sequencer #(
  parameter int DEPTH = 8,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [15:0]   in_b,
  input  logic          start,
  input  logic [15:0]   a_init,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [IW-1:0] err_index,
  output logic [15:0]   result
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [IW:0]   COUNT_FULL = (IW+1)'(DEPTH);
  localparam logic [IW:0]   COUNT_ONE  = (IW+1)'(1);
  localparam logic [IW-1:0] PTR_ONE    = IW'(1);

  state_t          state;
  logic [18:0]     mem [DEPTH];
  logic [IW-1:0]   wr_ptr;
  logic [IW-1:0]   rd_ptr;
  logic [IW:0]     count;
  logic [IW-1:0]   index;
  logic [15:0]     a_lat;

  logic            wr_en;
  logic            start_ok;
  logic            alu_rst;
  logic            alu_en;
  logic [15:0]     alu_acc;
  logic            alu_status;

  assign in_ready = (state == S_IDLE) && (count < COUNT_FULL);
  assign wr_en    = in_valid && in_ready;
  // Pre-edge count: an entry written in the same cycle does not make an
  // empty buffer startable.
  assign start_ok = (state == S_IDLE) && start && (count != '0);

  // The ALU is re-seeded for every program by holding it in reset in LOAD;
  // outside ISSUE it is disabled so its accumulator and status hold.
  assign alu_rst = rst || (state == S_LOAD);
  assign alu_en  = (state == S_ISSUE);

  alu_acc16 u_alu (
    .clk    (clk),
    .rst    (alu_rst),
    .en     (alu_en),
    .op     (mem[rd_ptr][18:16]),
    .a      (a_lat),
    .b      (mem[rd_ptr][15:0]),
    .acc    (alu_acc),
    .status (alu_status)
  );

  // Buffer storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {in_op, in_b};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      index     <= '0;
      a_lat     <= 16'h0000;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_index <= '0;
      result    <= 16'h0000;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            count  <= count + COUNT_ONE;
          end
          if (start_ok) begin
            a_lat     <= a_init;
            err       <= 1'b0;
            err_index <= '0;
            busy      <= 1'b1;
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          index <= '0;
          state <= S_ISSUE;
        end
        S_ISSUE: begin
          rd_ptr <= rd_ptr + PTR_ONE;
          count  <= count - COUNT_ONE;
          state  <= S_CHECK;
        end
        S_CHECK: begin
          if (alu_status) begin
            // Abort: the rest of the program is discarded.
            err       <= 1'b1;
            err_index <= index;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            result    <= alu_acc;
            done      <= 1'b1;
            state     <= S_DONE;
          end else if (count == '0) begin
            result <= alu_acc;
            done   <= 1'b1;
            state  <= S_DONE;
          end else begin
            index <= index + PTR_ONE;
            state <= S_ISSUE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sequencer
// Purpose  : Self-checking bench for alu_sequencer. Directed scenarios plus
//            random programs, compared against a queue-based program model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;
  localparam logic [2:0] ADD    = 3'd0;
  localparam logic [2:0] SUB    = 3'd1;
  localparam logic [2:0] MULT   = 3'd2;
  localparam logic [2:0] SHIFTL = 3'd3;
  localparam logic [2:0] AND_OP = 3'd4;
  localparam logic [2:0] OR_OP  = 3'd5;
  localparam logic [2:0] XOR_OP = 3'd6;
  localparam logic [2:0] NOT_OP = 3'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [15:0] in_b;
  logic        start;
  logic [15:0] a_init;
  logic        busy;
  logic        done;
  logic        err;
  logic [2:0]  err_index;
  logic [15:0] result;

  int n_assert = 0;
  int n_fail   = 0;

  logic [18:0] prog_q[$];

  alu_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_b      (in_b),
    .start     (start),
    .a_init    (a_init),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_index (err_index),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Executes the queued program on plain integers and derives the outcome
  // and the cycle (relative to start) in which done must appear.
  task automatic model_run(input logic [15:0] a0, output logic [15:0] res,
                           output logic e, output int idx, output int cyc);
    longint acc;
    longint r;
    logic [2:0]  op;
    logic [15:0] b;
    acc = a0;
    e   = 1'b0;
    idx = 0;
    res = a0;
    cyc = 2 * prog_q.size() + 2;
    for (int k = 0; k < prog_q.size(); k++) begin
      op = prog_q[k][18:16];
      b  = prog_q[k][15:0];
      case (op)
        ADD:     r = acc + b;
        SUB:     r = acc - b;
        MULT:    r = acc * b;
        SHIFTL:  r = acc << b[3:0];
        AND_OP:  r = acc & b;
        OR_OP:   r = acc | b;
        XOR_OP:  r = acc ^ b;
        default: r = (~acc) & 64'hFFFF;
      endcase
      res = r[15:0];
      if (r < 0 || r > 65535) begin
        e   = 1'b1;
        idx = k;
        cyc = 2 * k + 4;
        break;
      end
      acc = r;
    end
  endtask

  task automatic push(input logic [2:0] op, input logic [15:0] b);
    in_valid = 1'b1;
    in_op    = op;
    in_b     = b;
    chk("push_ready", {31'd0, in_ready}, 32'd1);
    prog_q.push_back({op, b});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_prog(input logic [15:0] a, input string tag,
                          output logic [15:0] o_res, output int o_cyc);
    logic [15:0] eres;
    logic        eerr;
    int          eidx;
    int          ecyc;
    int          cyc;
    model_run(a, eres, eerr, eidx, ecyc);
    start  = 1'b1;
    a_init = a;
    @(negedge clk);
    // start stays high in cycle 1 to show a start during busy is ignored;
    // a_init is scrambled to show the seed was latched.
    a_init = 16'($urandom);
    cyc    = 1;
    chk({tag, "_busy1"}, {31'd0, busy}, 32'd1);
    chk({tag, "_ready1"}, {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    cyc   = 2;
    while (done !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done_cycle"}, cyc, ecyc);
    chk({tag, "_result"}, {16'd0, result}, {16'd0, eres});
    chk({tag, "_err"}, {31'd0, err}, {31'd0, eerr});
    if (eerr) chk({tag, "_err_index"}, {29'd0, err_index}, eidx);
    chk({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
    o_res = result;
    o_cyc = cyc;
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
    prog_q.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_err_index"}, {29'd0, err_index}, 32'd0);
    chk({tag, "_result"}, {16'd0, result}, 32'd0);
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [15:0] res;
    int          cyc;
    int          len;
    logic [2:0]  op;
    logic [15:0] b;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_op    = 3'd0;
    in_b     = 16'd0;
    start    = 1'b0;
    a_init   = 16'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset");

    // Start with an empty buffer is ignored.
    start  = 1'b1;
    a_init = 16'd42;
    @(negedge clk);
    start = 1'b0;
    chk("empty_start_busy", {31'd0, busy}, 32'd0);
    chk("empty_start_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    chk("empty_start_done", {31'd0, done}, 32'd0);
    chk("empty_start_busy2", {31'd0, busy}, 32'd0);

    // Write and start together with count=0: write taken, start ignored.
    in_valid = 1'b1;
    in_op    = ADD;
    in_b     = 16'd7;
    start    = 1'b1;
    a_init   = 16'd9;
    chk("simul_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
    prog_q.push_back({ADD, 16'd7});
    chk("simul_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("simul_busy2", {31'd0, busy}, 32'd0);
    run_prog(16'd1, "simul_run", res, cyc);
    chk("simul_result_const", {16'd0, res}, 32'd8);

    // Normal chain.
    push(ADD, 16'd3);
    push(SUB, 16'd2);
    push(MULT, 16'd4);
    run_prog(16'd5, "chain", res, cyc);
    chk("chain_result_const", {16'd0, res}, 32'd24);
    chk("chain_cycle_const", cyc, 32'd8);

    // Carry on the first instruction flushes the rest.
    push(ADD, 16'd1);
    push(OR_OP, 16'h00F0);
    run_prog(16'hFFFF, "carry", res, cyc);
    chk("carry_cycle_const", cyc, 32'd4);
    chk("carry_err_const", {31'd0, err}, 32'd1);
    chk("carry_idx_const", {29'd0, err_index}, 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("carry_flushed_busy", {31'd0, busy}, 32'd0);
    chk("carry_err_held", {31'd0, err}, 32'd1);

    // Multiply overflow at index 1.
    push(AND_OP, 16'hFFFF);
    push(MULT, 16'h0100);
    run_prog(16'h0100, "mult", res, cyc);
    chk("mult_cycle_const", cyc, 32'd6);
    chk("mult_idx_const", {29'd0, err_index}, 32'd1);

    // Full buffer and backpressure: nine offers, eight accepted.
    for (int i = 0; i < 9; i++) begin
      op = 3'(AND_OP + 3'($urandom_range(0, 3)));
      b  = 16'($urandom);
      in_valid = 1'b1;
      in_op    = op;
      in_b     = b;
      chk("full_ready", {31'd0, in_ready}, (i < 8) ? 32'd1 : 32'd0);
      if (i < 8) prog_q.push_back({op, b});
      @(negedge clk);
    end
    in_valid = 1'b0;
    run_prog(16'($urandom), "full", res, cyc);
    chk("full_cycle_const", cyc, 32'd18);

    // Random programs.
    for (int t = 0; t < 8; t++) begin
      len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++) begin
        op = 3'($urandom_range(0, 7));
        b  = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 15)) : 16'($urandom);
        push(op, b);
      end
      run_prog(16'($urandom_range(0, 300)), "random", res, cyc);
    end

    // Reset in the ISSUE cycle of instruction 1.
    push(ADD, 16'd1);
    push(ADD, 16'd2);
    push(ADD, 16'd3);
    start  = 1'b1;
    a_init = 16'd10;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (cyc < 4) begin
      chk("rst_mid_no_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      cyc++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    prog_q.delete();
    chk_reset_outputs("rst_mid");
    @(negedge clk);
    chk("rst_mid_no_done_after", {31'd0, done}, 32'd0);
    chk("rst_mid_idle", {31'd0, busy}, 32'd0);
    push(SUB, 16'd4);
    push(SHIFTL, 16'd1);
    run_prog(16'd20, "after_rst", res, cyc);
    chk("after_rst_result_const", {16'd0, res}, 32'd32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no end of test, expected completion");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire

// File: doc/alu_sequencer.md
# alu_sequencer

Program-driven controller wrapped around the 16-bit accumulator ALU. Buffers a short program of (opcode, operand) instructions, resets the ALU and seeds it with an initial operand, then issues one instruction every two cycles. After each issue it checks the ALU status flag. On completion or on the first carry/overflow error it reports the final accumulator value, a done pulse and error information. It sits between the host/test logic and the ALU, which it instantiates and fully owns.

## Interface
Parameters:
- DEPTH, 8, program buffer entries; power of two, at least 2.
- IW, log2(DEPTH), width of instruction index and pointers.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  host offers an instruction.
- in_ready  out  1  buffer accepts an instruction this cycle.
- in_op  in  3  ALU opcode, using the codebase opcode macros (ADD, SUB, MULT, SHIFTL, AND, OR, XOR, NOT).
- in_b  in  16  B operand for that instruction.
- start  in  1  begin executing the buffered program.
- a_init  in  16  initial A operand; sampled when start is accepted.
- busy  out  1  program executing (state is not IDLE).
- done  out  1  one-cycle pulse when the program ends, whether normally or by error.
- err  out  1  last program aborted on an ALU error; held until the next accepted start.
- err_index  out  IW  index (0-based) of the faulting instruction; valid when err=1.
- result  out  16  ALU accumulator captured at program end; held until the next done.

## Operation
- The buffer is a FIFO of DEPTH entries, each {op, b}. It uses wrap-around read/write pointers and an IW+1-bit count.
- Write handshake: a write occurs when in_valid & in_ready. in_ready = (state==IDLE) & (count<DEPTH).
- start is accepted only when state==IDLE and the pre-edge count>0. Otherwise it is ignored with no side effects.
- If a write and an accepted start occur in the same cycle, the written entry is part of the program.
- ALU reset = rst | (state==LOAD). The ALU opcode is the NOOP/hold code in every state except ISSUE. The ALU A input is a_init as latched at start.
- State machine:
  - IDLE: on an accepted start, latch a_init, clear err and err_index, go to LOAD.
  - LOAD: ALU held in reset for one cycle, which clears its accumulator and first-op flag. Clear the instruction index. Go to ISSUE.
  - ISSUE: drive the ALU with opcode = head.op and B = head.b. Pop the head. Go to CHECK.
  - CHECK: ALU opcode is hold. Sample ALU status.
    - If status=1: err<=1, err_index<=index, flush the FIFO (count and pointers to 0), go to DONE.
    - Else if the FIFO is empty: go to DONE.
    - Else: index<=index+1, go to ISSUE.
  - DONE: done=1 for this cycle. Go to IDLE.
- result is registered from the ALU output on the CHECK->DONE edge. On an error it holds whatever the ALU produced.
- The first ISSUE uses a_init as A. Each later ISSUE uses the ALU accumulator as A.
- Arithmetic is the ALU's, unsigned 16-bit. The controller does no arithmetic beyond pointer, count and index updates.

## Timing
- On reset: state IDLE, FIFO empty, in_ready=1 on the cycle after reset deasserts, busy=0, done=0, err=0, err_index=0, result=0. The ALU is also reset.
- Let the start cycle be 0. LOAD is cycle 1. Instruction k is issued in cycle 2+2k and checked in cycle 3+2k.
- For a program of N instructions with no error, done is high in cycle 2N+2.
- For an error at instruction k, done is high in cycle 2k+4.
- busy is high from cycle 1 through the DONE cycle inclusive.
- rst asserted mid-program: the next cycle is IDLE with all outputs at reset values. No done pulse is generated, and the buffered program is discarded.
- start during busy is ignored. in_valid during busy is not accepted because in_ready=0.

## Test plan
- Normal chain: a_init=5; program ADD 3, SUB 2, MULT 4; start at cycle 0. Required: done in cycle 8, result=24, err=0.
- Add carry: a_init=16'hFFFF; program ADD 1, OR 16'h00F0. Required: done in cycle 4, err=1, err_index=0, FIFO empty, in_ready=1 afterwards.
- Mult overflow at a later index: a_init=16'h0100; program AND 16'hFFFF, MULT 16'h0100. Required: err=1, err_index=1, done in cycle 6.
- Full/backpressure: write 8 entries back-to-back with in_valid held. Required: in_ready drops after the 8th write and a 9th is not accepted. Then start and confirm all 8 execute, with done in cycle 18.
- Empty start, then simultaneous events: start with an empty FIFO, then done, busy and err stay 0. Next, assert in_valid (ADD 7) and start in the same cycle with count=0: the write is accepted and start is ignored. A later start with a_init=1 gives result=8.
- Reset mid-run: assert rst in the ISSUE cycle of instruction 1 of a 3-instruction program. Required: no done, all outputs at reset values, in_ready=1. A new program then runs correctly from a fresh ALU reset.
